// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the channels enabled in a latched 32-bit mask in
// ascending order, drives the select of an external word mux, captures the
// mux output and presents each word with its channel number on a valid/ready
// stream. A one-cycle done pulse marks the end of each sweep.
//
// Build option SCAN_CONTINUOUS_EN: when defined, holding start high at the
// handshake on the highest enabled channel wraps the scan back to the lowest
// enabled channel instead of finishing the sweep.
module mux_scan_sequencer #(
    parameter int WIDTH = 16,
    parameter int NCH   = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NCH-1:0]   ch_mask,
    output logic [SEL_W-1:0] s,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEL  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [NCH-1:0]   mask_reg, mask_next;
    logic [SEL_W-1:0] s_reg, s_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [SEL_W-1:0] out_ch_reg, out_ch_next;
    logic             out_valid_reg, out_valid_next;

    // Enabled channels strictly above the current select; channel 31 has
    // nothing above it, so the scan never wraps on its own.
    logic [NCH-1:0]   above;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_above
            localparam logic [SEL_W-1:0] CH = SEL_W'(gi);
            assign above[gi] = mask_reg[gi] & (CH > s_reg);
        end
    endgenerate

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SEL_W'(i);
            end
        end
        return idx;
    endfunction

    // Next-state and datapath decisions for the sweep FSM.
    always_comb begin
        state_next     = state_reg;
        mask_next      = mask_reg;
        s_next         = s_reg;
        out_data_next  = out_data_reg;
        out_ch_next    = out_ch_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (|ch_mask) begin
                        mask_next  = ch_mask;
                        s_next     = lowest_set(ch_mask);
                        state_next = SEL;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            SEL: begin
                // s has been stable for a full cycle, so d is settled here.
                out_data_next  = d;
                out_ch_next    = s_reg;
                out_valid_next = 1'b1;
                state_next     = HOLD;
            end
            HOLD: begin
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    if (|above) begin
                        s_next     = lowest_set(above);
                        state_next = SEL;
                    end else begin
`ifdef SCAN_CONTINUOUS_EN
                        if (start) begin
                            s_next     = lowest_set(mask_reg);
                            state_next = SEL;
                        end else begin
                            state_next = FIN;
                        end
`else
                        state_next = FIN;
`endif
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mask_reg      <= '0;
            s_reg         <= '0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mask_reg      <= mask_next;
            s_reg         <= s_next;
            out_data_reg  <= out_data_next;
            out_ch_reg    <= out_ch_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign s         = s_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FIN);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer: table of sweep masks with expected word
// count and first/last channel, randomized sweeps scored against a list of
// (channel, word) pairs derived directly from the mask, plus hand-written
// sequences for backpressure, empty mask, reset mid-sweep and (when built
// with SCAN_CONTINUOUS_EN) continuous scanning.
module tb_mux_scan_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] ch_mask;
    logic [4:0]  s;
    logic [15:0] d;
    logic [15:0] out_data;
    logic [4:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    // Behavioural stand-in for the 32:1 word mux.
    logic [15:0] a_mem [32];
    assign d = a_mem[s];

    int vectors;
    int miscompares;
    int done_cnt;
    int got_ch[$];
    int got_data[$];

    mux_scan_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ch_mask   (ch_mask),
        .s         (s),
        .d         (d),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream monitor: records handshakes, counts done pulses and checks that
    // a stalled word stays put until it is accepted.
    initial begin
        logic        prev_stall;
        logic        prev_rst;
        logic [4:0]  prev_ch;
        logic [4:0]  prev_s;
        logic [15:0] prev_data;
        prev_stall = 1'b0;
        prev_rst   = 1'b1;
        prev_ch    = '0;
        prev_s     = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                check("valid_sel", 32'(s), 32'(out_ch));
                check("valid_data", 32'(out_data), 32'(a_mem[out_ch]));
            end
            if (prev_stall && !prev_rst) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_ch", 32'(out_ch), 32'(prev_ch));
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_s", 32'(s), 32'(prev_s));
            end
            if (out_valid && out_ready && !rst) begin
                got_ch.push_back(int'(out_ch));
                got_data.push_back(int'(out_data));
            end
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_rst   = rst;
            prev_ch    = out_ch;
            prev_s     = s;
            prev_data  = out_data;
        end
    end

    task automatic fill_mux();
        for (int i = 0; i < 32; i++) a_mem[i] = 16'($urandom);
    endtask

    // One full sweep; afterwards the captured words are compared with the
    // enabled channels of m in ascending order, each carrying its mux word.
    task automatic do_sweep(input logic [31:0] m, input int ready_pct);
        int base;
        int cyc;
        int exp_ch[$];
        got_ch.delete();
        got_data.delete();
        base = done_cnt;
        ch_mask   = m;
        start     = 1'b1;
        out_ready = ($urandom_range(99) < ready_pct);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done_cnt == base && cyc < 2000) begin
            out_ready = ($urandom_range(99) < ready_pct);
            ch_mask   = $urandom;
`ifndef SCAN_CONTINUOUS_EN
            if (busy && $urandom_range(3) == 0) start = 1'b1;
`endif
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        if (cyc >= 2000) begin
            miscompares++;
            $display("FAIL sweep_timeout: no done within 2000 cycles, mask 0x%08h", m);
        end
        check("idle_after_done_busy", 32'(busy), 32'd0);
        check("idle_after_done_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("single_done", 32'(done_cnt - base), 32'd1);
        for (int i = 0; i < 32; i++) if (m[i]) exp_ch.push_back(i);
        check("word_count", 32'(got_ch.size()), 32'(exp_ch.size()));
        for (int i = 0; i < exp_ch.size() && i < got_ch.size(); i++) begin
            check("word_ch", 32'(got_ch[i]), 32'(exp_ch[i]));
            check("word_data", 32'(got_data[i]), 32'(a_mem[exp_ch[i]]));
        end
    endtask

    typedef struct {
        logic [31:0] mask;
        int          nwords;
        int          first_ch;
        int          last_ch;
        int          ready_pct;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   cyc;
        int   base;
        tbl[0] = '{32'h0000_0400,  1, 10, 10, 100};
        tbl[1] = '{32'h8200_0011,  4,  0, 31, 100};
        tbl[2] = '{32'h8200_0011,  4,  0, 31,  40};
        tbl[3] = '{32'h8000_0000,  1, 31, 31,  70};
        tbl[4] = '{32'h0000_0001,  1,  0,  0, 100};
        tbl[5] = '{32'hFFFF_FFFF, 32,  0, 31,  60};
        tbl[6] = '{32'h0000_0000,  0, -1, -1, 100};

        vectors = 0;
        miscompares = 0;
        done_cnt = 0;
        rst = 1'b1;
        start = 1'b0;
        ch_mask = '0;
        out_ready = 1'b0;
        fill_mux();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_s", 32'(s), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Table-driven sweeps.
        a_mem[10] = 16'h420D;
        for (int t = 0; t < 7; t++) begin
            do_sweep(tbl[t].mask, tbl[t].ready_pct);
            check("tbl_nwords", 32'(got_ch.size()), 32'(tbl[t].nwords));
            if (tbl[t].nwords > 0 && got_ch.size() > 0) begin
                check("tbl_first_ch", 32'(got_ch[0]), 32'(tbl[t].first_ch));
                check("tbl_last_ch", 32'(got_ch[got_ch.size()-1]), 32'(tbl[t].last_ch));
            end
            if (t == 0 && got_data.size() > 0) check("ch10_word", 32'(got_data[0]), 32'h420D);
        end

        // Backpressure on channel 17, then done one cycle after the handshake.
        got_ch.delete();
        got_data.delete();
        out_ready = 1'b0;
        ch_mask = 32'h0002_0000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("bp_still_valid", 32'(out_valid), 32'd1);
        check("bp_out_ch", 32'(out_ch), 32'd17);
        check("bp_s", 32'(s), 32'd17);
        check("bp_no_accept", 32'(got_ch.size()), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_done", 32'(done), 32'd1);
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_accepted", 32'(got_ch.size()), 32'd1);
        @(posedge clk); #1;
        check("bp_idle", 32'(busy), 32'd0);

        // Empty mask: one busy cycle carrying done; start during FIN ignored.
        ch_mask = '0;
        start = 1'b1;
        @(posedge clk); #1;
        check("empty_busy", 32'(busy), 32'd1);
        check("empty_done", 32'(done), 32'd1);
        check("empty_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("empty_busy_end", 32'(busy), 32'd0);
        check("empty_done_end", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("fin_start_ignored", 32'(busy), 32'd0);

        // Reset on the second HOLD cycle of channel 4, then a fresh sweep.
        out_ready = 1'b0;
        ch_mask = 32'h0000_0110;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rstmid_ch", 32'(out_ch), 32'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_s", 32'(s), 32'd0);
        check("rstmid_out_data", 32'(out_data), 32'd0);
        check("rstmid_out_ch", 32'(out_ch), 32'd0);
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        do_sweep(32'h0000_0110, 100);

        // Randomized sweeps.
        for (int r = 0; r < 20; r++) begin
            fill_mux();
            do_sweep($urandom & $urandom | (32'd1 << $urandom_range(31)), 60);
        end

`ifdef SCAN_CONTINUOUS_EN
        // Continuous scan: 1,2,1,2,... while start is held, no done.
        got_ch.delete();
        got_data.delete();
        base = done_cnt;
        ch_mask = 32'h0000_0006;
        out_ready = 1'b1;
        start = 1'b1;
        cyc = 0;
        while (got_ch.size() < 6 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("cont_words", 32'(got_ch.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < got_ch.size(); i++)
            check("cont_ch", 32'(got_ch[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        check("cont_no_done", 32'(done_cnt - base), 32'd0);
        cyc = 0;
        while (done_cnt == base && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("cont_done", 32'(done_cnt - base), 32'd1);
        if (got_ch.size() > 0) check("cont_last_ch", 32'(got_ch[got_ch.size()-1]), 32'd2);
`else
        base = done_cnt;
        check("done_count_stable", 32'(done_cnt), 32'(base));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
